// File: rtl/reg_file_bist_if.sv
// reg_file_bist_if: write/read port between the BIST initiator and the register file.
interface reg_file_bist_if #(
    parameter int DATA_WIDTH = 4,
    parameter int ADDR_WIDTH = 2
);
    logic                  write_enable;
    logic [ADDR_WIDTH-1:0] write_in_address;
    logic [DATA_WIDTH-1:0] write_in_data;
    logic                  read_enable;
    logic [ADDR_WIDTH-1:0] read_out_address;
    logic [DATA_WIDTH-1:0] rd_data;
    modport master (
        output write_enable, write_in_address, write_in_data, read_enable, read_out_address,
        input  rd_data
    );
    modport slave (
        input  write_enable, write_in_address, write_in_data, read_enable, read_out_address,
        output rd_data
    );
endinterface

// File: rtl/reg_file_bist.sv
// reg_file_bist: writes (pattern + address) into every register file word,
// reads each word back after READ_LATENCY cycles and reports pass/err_count/fail_addr.
module reg_file_bist #(
    parameter int DATA_WIDTH   = 4,
    parameter int ADDR_WIDTH   = 2,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] pattern,
    reg_file_bist_if.master       bus,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [ADDR_WIDTH:0]   err_count,
    output logic [ADDR_WIDTH-1:0] fail_addr
);
    localparam int CW = READ_LATENCY > 0 ? $clog2(READ_LATENCY + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(READ_LATENCY);
    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = '1;

    typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] pat_q, pat_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] wa_q, wa_d;
    logic [DATA_WIDTH-1:0] wd_q, wd_d;
    logic                  re_q, re_d;
    logic [ADDR_WIDTH-1:0] ra_q, ra_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  pass_q, pass_d;
    logic [ADDR_WIDTH:0]   err_q, err_d;
    logic [ADDR_WIDTH-1:0] fail_q, fail_d;
    logic [DATA_WIDTH-1:0] exp_rd;

    assign exp_rd = pat_q + DATA_WIDTH'(ra_q);

    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        we_d    = we_q;
        wa_d    = wa_q;
        wd_d    = wd_q;
        re_d    = re_q;
        ra_d    = ra_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        pass_d  = pass_q;
        err_d   = err_q;
        fail_d  = fail_q;
        case (state_q)
            IDLE: if (start) begin
                pat_d   = pattern;
                err_d   = '0;
                fail_d  = '0;
                pass_d  = 1'b0;
                busy_d  = 1'b1;
                we_d    = 1'b1;
                wa_d    = '0;
                wd_d    = pattern;
                state_d = WRITE;
            end
            WRITE: if (wa_q == ADDR_LAST) begin
                we_d    = 1'b0;
                re_d    = 1'b1;
                ra_d    = '0;
                cnt_d   = '0;
                state_d = READ;
            end else begin
                wa_d = wa_q + ADDR_WIDTH'(1);
                wd_d = pat_q + DATA_WIDTH'(wa_d);
            end
            READ: if (cnt_q != CNT_LAST) begin
                cnt_d = cnt_q + CW'(1);
            end else begin
                if (bus.rd_data != exp_rd) begin
                    err_d  = err_q + (ADDR_WIDTH + 1)'(1);
                    fail_d = err_q == '0 ? ra_q : fail_q;
                end
                cnt_d = '0;
                if (ra_q == ADDR_LAST) begin
                    re_d    = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = err_d == '0;
                    state_d = DONE;
                end else begin
                    ra_d = ra_q + ADDR_WIDTH'(1);
                end
            end
            DONE: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            pat_q   <= '0;
            we_q    <= 1'b0;
            wa_q    <= '0;
            wd_q    <= '0;
            re_q    <= 1'b0;
            ra_q    <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            fail_q  <= '0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            we_q    <= we_d;
            wa_q    <= wa_d;
            wd_q    <= wd_d;
            re_q    <= re_d;
            ra_q    <= ra_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            fail_q  <= fail_d;
        end
    end

    assign bus.write_enable     = we_q;
    assign bus.write_in_address = wa_q;
    assign bus.write_in_data    = wd_q;
    assign bus.read_enable      = re_q;
    assign bus.read_out_address = ra_q;
    assign busy                 = busy_q;
    assign done                 = done_q;
    assign pass                 = pass_q;
    assign err_count            = err_q;
    assign fail_addr            = fail_q;
endmodule

// File: tb/tb_reg_file_bist.sv
// tb_reg_file_bist: two BIST instances (READ_LATENCY 1 and 0) against behavioural
// register files, with a queue scoreboard of expected writes and test results.
module tb_reg_file_bist;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start0 = 1'b0, start1 = 1'b0;
    logic [3:0] pattern0 = '0, pattern1 = '0;
    logic fault0 = 1'b0, fault1 = 1'b0;
    logic busy0, done0, pass0, busy1, done1, pass1;
    logic [2:0] err0, err1;
    logic [1:0] fail0, fail1;
    int cyc = 0;
    int total = 0;
    int bad = 0;
    int lastp [2];
    int laste [2];
    int lastf [2];

    typedef struct {int pass; int err; int fail; int lat; int k;} exp_t;
    typedef struct {int a; int d;} wr_t;
    exp_t q0[$], q1[$];
    wr_t  w0[$], w1[$];

    reg_file_bist_if #(.DATA_WIDTH(4), .ADDR_WIDTH(2)) b0 ();
    reg_file_bist_if #(.DATA_WIDTH(4), .ADDR_WIDTH(2)) b1 ();

    reg_file_bist #(.DATA_WIDTH(4), .ADDR_WIDTH(2), .READ_LATENCY(1)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .pattern(pattern0), .bus(b0),
        .busy(busy0), .done(done0), .pass(pass0), .err_count(err0), .fail_addr(fail0)
    );
    reg_file_bist #(.DATA_WIDTH(4), .ADDR_WIDTH(2), .READ_LATENCY(0)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .pattern(pattern1), .bus(b1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1), .fail_addr(fail1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // register file models: registered read for dut0, combinational for dut1
    logic [3:0] mem0 [4];
    logic [3:0] mem1 [4];
    logic [3:0] rd0_q;
    always @(posedge clk) begin
        if (b0.write_enable) mem0[b0.write_in_address] <= b0.write_in_data;
        if (b1.write_enable) mem1[b1.write_in_address] <= b1.write_in_data;
        rd0_q <= mem0[b0.read_out_address];
    end
    assign b0.rd_data = fault0 ? (rd0_q & 4'hE) : rd0_q;
    assign b1.rd_data = fault1 ? (mem1[b1.read_out_address] & 4'hE) : mem1[b1.read_out_address];

    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d at cycle %0d", n, got, exp, cyc);
        end
    endtask

    function automatic int qsize(input int j);
        return j == 0 ? q0.size() : q1.size();
    endfunction

    function automatic int wsize(input int j);
        return j == 0 ? w0.size() : w1.size();
    endfunction

    task automatic push_exp(input int j, input int pat, input int flt, input int k);
        exp_t x;
        wr_t  w;
        int   e, r;
        x.err  = 0;
        x.fail = 0;
        x.k    = k;
        x.lat  = 4 + 4 * ((j == 0 ? 1 : 0) + 1) + 1;
        for (int a = 0; a < 4; a++) begin
            e = (pat + a) % 16;
            r = flt != 0 ? (e & 14) : e;
            if (r != e) begin
                if (x.err == 0) x.fail = a;
                x.err++;
            end
            w.a = a;
            w.d = e;
            if (j == 0) w0.push_back(w); else w1.push_back(w);
        end
        x.pass = x.err == 0 ? 1 : 0;
        if (j == 0) q0.push_back(x); else q1.push_back(x);
    endtask

    task automatic on_write(input int j, input logic [1:0] a, input logic [3:0] d);
        wr_t w;
        chk($sformatf("wr_expected%0d", j), wsize(j) != 0, 1);
        if (wsize(j) != 0) begin
            if (j == 0) w = w0.pop_front(); else w = w1.pop_front();
            chk($sformatf("wr_addr%0d", j), a, w.a);
            chk($sformatf("wr_data%0d", j), d, w.d);
        end
    endtask

    task automatic on_done(input int j, input logic b, input logic p, input logic [2:0] e, input logic [1:0] f);
        exp_t x;
        chk($sformatf("done_expected%0d", j), qsize(j) != 0, 1);
        if (qsize(j) != 0) begin
            if (j == 0) x = q0.pop_front(); else x = q1.pop_front();
            chk($sformatf("latency%0d", j), cyc - x.k + 1, x.lat);
            chk($sformatf("pass%0d", j), p, x.pass);
            chk($sformatf("err_count%0d", j), e, x.err);
            chk($sformatf("fail_addr%0d", j), f, x.fail);
            chk($sformatf("busy_at_done%0d", j), b, 0);
            lastp[j] = x.pass;
            laste[j] = x.err;
            lastf[j] = x.fail;
        end
    endtask

    always @(negedge clk) begin
        chk("we_re_excl0", b0.write_enable & b0.read_enable, 0);
        chk("we_re_excl1", b1.write_enable & b1.read_enable, 0);
        if (b0.write_enable) on_write(0, b0.write_in_address, b0.write_in_data);
        if (b1.write_enable) on_write(1, b1.write_in_address, b1.write_in_data);
        if (done0) on_done(0, busy0, pass0, err0, fail0);
        if (done1) on_done(1, busy1, pass1, err1, fail1);
    end

    // mode 0: plain start, 1: extra start pulse mid-test, 2: start held through DONE
    task automatic begin_test(input int j, input int pat, input int flt, input int mode);
        int k, o;
        @(negedge clk);
        if (j == 0) begin pattern0 = 4'(pat); fault0 = flt[0]; start0 = 1'b1; end
        else begin pattern1 = 4'(pat); fault1 = flt[0]; start1 = 1'b1; end
        @(posedge clk);
        #1;
        k = cyc;
        push_exp(j, pat, flt, k);
        if (mode == 2) push_exp(j, pat, flt, k + (j == 0 ? 14 : 10));
        chk($sformatf("busy_after_start%0d", j), j == 0 ? busy0 : busy1, 1);
        repeat (mode == 2 ? (j == 0 ? 15 : 11) : 1) @(negedge clk);
        if (j == 0) start0 = 1'b0; else start1 = 1'b0;
        if (mode == 1) begin
            o = $urandom_range(1, j == 0 ? 12 : 8);
            repeat (o) @(negedge clk);
            if (j == 0) start0 = 1'b1; else start1 = 1'b1;
            @(negedge clk);
            if (j == 0) start0 = 1'b0; else start1 = 1'b0;
        end
    endtask

    task automatic finish_test(input int j);
        for (int i = 0; i < 200; i++) begin
            if (qsize(j) == 0) break;
            @(negedge clk);
            #1;
        end
        chk($sformatf("done_wait%0d", j), qsize(j), 0);
        repeat (3) @(negedge clk);
        chk($sformatf("pass_hold%0d", j), j == 0 ? pass0 : pass1, lastp[j]);
        chk($sformatf("err_hold%0d", j), j == 0 ? err0 : err1, laste[j]);
        chk($sformatf("fail_hold%0d", j), j == 0 ? fail0 : fail1, lastf[j]);
        chk($sformatf("idle_busy%0d", j), j == 0 ? busy0 : busy1, 0);
    endtask

    task automatic run(input int j, input int pat, input int flt, input int mode);
        begin_test(j, pat, flt, mode);
        finish_test(j);
    endtask

    initial begin
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs0", {b0.write_enable, b0.write_in_address, b0.write_in_data, b0.read_enable,
            b0.read_out_address, busy0, done0, pass0, err0, fail0}, 0);
        chk("reset_outputs1", {b1.write_enable, b1.write_in_address, b1.write_in_data, b1.read_enable,
            b1.read_out_address, busy1, done1, pass1, err1, fail1}, 0);
        rst = 1'b1;
        @(negedge clk);
        run(0, 4'h3, 0, 0);
        run(0, 4'hF, 0, 0);
        run(0, 4'h3, 1, 0);
        run(0, 4'h3, 0, 1);
        begin_test(0, 4'h7, 0, 0);
        repeat (2) @(negedge clk);
        chk("mid_write_we", b0.write_enable, 1);
        chk("mid_write_addr", b0.write_in_address, 2);
        rst = 1'b0;
        #1;
        chk("abort_we", b0.write_enable, 0);
        chk("abort_busy", busy0, 0);
        chk("abort_outputs", {b0.write_in_address, b0.write_in_data, b0.read_enable, done0, pass0, err0, fail0}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        q0.delete();
        w0.delete();
        q1.delete();
        w1.delete();
        @(negedge clk);
        run(0, 4'hA, 0, 0);
        run(1, 4'h0, 0, 0);
        run(0, 4'h5, 0, 2);
        run(1, 4'hE, 1, 2);
        for (int i = 0; i < 12; i++)
            run(i % 2, $urandom_range(0, 15), $urandom_range(0, 1), $urandom_range(0, 2));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
